// File: rtl/bias_load_ctrl_pkg.sv
// bias_load_ctrl_pkg: shared FSM state encoding and FP32 field constants for the bias loader.
package bias_load_ctrl_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT,
        S_CONV,
        S_OUT,
        S_DONE
    } state_e;

    localparam int SIGN_BIT = 31;
    localparam int EXP_MSB  = 30;
    localparam int EXP_LSB  = 23;
    localparam int EXP_BIAS = 127;
    localparam int EXP_SAT  = 133;

endpackage

// File: rtl/bias_load_ctrl_converter.sv
// converter: maps an FP32 bias to 8-bit sign-magnitude; magnitude is registered on en,
// sign follows in_bias combinationally.
module converter
    import bias_load_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [31:0] in_bias,
    output logic [7:0]  out_bias
);

    logic [7:0] exp_w;
    logic [6:0] mant_top;
    logic [6:0] mag_q, mag_d;

    assign exp_w    = in_bias[EXP_MSB:EXP_LSB];
    assign mant_top = in_bias[EXP_LSB-1 -: 7];

    // Exponent 127..133 keeps the top (exp-126) mantissa bits, i.e. drops (133-exp) of the 7.
    always_comb begin
        mag_d = exp_w < 8'(EXP_BIAS) ? 7'd0
              : exp_w > 8'(EXP_SAT)  ? 7'd127
              : mant_top >> (8'(EXP_SAT) - exp_w);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) mag_q <= '0;
        else if (en) mag_q <= mag_d;
    end

    assign out_bias = {in_bias[SIGN_BIT], mag_q};

endmodule

// File: rtl/bias_load_ctrl.sv
// bias_load_ctrl: streams a block of FP32 biases from the bias ROM through one converter
// and presents the 8-bit results on a valid/ready stream, one bias per FETCH/WAIT/CONV/OUT pass.
module bias_load_ctrl
    import bias_load_ctrl_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int CNT_W  = 9
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [CNT_W-1:0]  num_bias,
    output logic              busy,
    output logic              done,
    output logic              err_zero,
    output logic              rom_en,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [31:0]       rom_rdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_idx,
    output logic [7:0]        out_bias,
    output logic [CNT_W-1:0]  sat_cnt
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CNT_W-1:0]  idx_q, idx_d;
    logic [CNT_W-1:0]  sat_q, sat_d;
    logic [31:0]       hold_q, hold_d;
    logic              err_q, err_d;
    logic [CNT_W-1:0]  idx_inc;
    logic              accept;
    logic              hs;
    logic              conv_rst;
    logic              conv_en;

    assign idx_inc  = idx_q + CNT_W'(1);
    assign accept   = (state_q == S_IDLE) && start;
    assign hs       = (state_q == S_OUT) && out_ready;
    assign conv_rst = ~rst;
    assign conv_en  = (state_q == S_CONV);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= S_IDLE;
        else state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = (num_bias == '0) ? S_DONE : S_FETCH;
            S_FETCH: state_d = S_WAIT;
            S_WAIT:  state_d = S_CONV;
            S_CONV:  state_d = S_OUT;
            S_OUT:   if (out_ready) state_d = (idx_inc == cnt_q) ? S_DONE : S_FETCH;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy      = state_q != S_IDLE;
        done      = state_q == S_DONE;
        err_zero  = (state_q == S_DONE) && err_q;
        rom_en    = state_q == S_FETCH;
        out_valid = state_q == S_OUT;
        rom_addr  = base_q + idx_q[ADDR_W-1:0];
        out_idx   = idx_q[ADDR_W-1:0];
        sat_cnt   = sat_q;
    end

    always_comb begin
        base_d = accept ? base_addr : base_q;
        cnt_d  = accept ? num_bias : cnt_q;
        err_d  = accept ? (num_bias == '0) : err_q;
        idx_d  = accept ? '0 : hs ? idx_inc : idx_q;
        hold_d = (state_q == S_WAIT) ? rom_rdata : hold_q;
        sat_d  = accept ? '0
               : (conv_en && hold_q[EXP_MSB:EXP_LSB] > 8'(EXP_SAT)) ? sat_q + CNT_W'(1)
               : sat_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            base_q <= '0;
            cnt_q  <= '0;
            idx_q  <= '0;
            sat_q  <= '0;
            hold_q <= '0;
            err_q  <= 1'b0;
        end else begin
            base_q <= base_d;
            cnt_q  <= cnt_d;
            idx_q  <= idx_d;
            sat_q  <= sat_d;
            hold_q <= hold_d;
            err_q  <= err_d;
        end
    end

    // Hold register stays put through OUT, so the combinational sign bit is stable under backpressure.
    converter u_conv (
        .clk      (clk),
        .rst      (conv_rst),
        .en       (conv_en),
        .in_bias  (hold_q),
        .out_bias (out_bias)
    );

endmodule
